uart_rx_ctrl: RTL and testbench

Sequencing controller for the UART receiver core. It generates the receiver's 3-per-bit sample pulses (`rxpulse`), phase-locked to the receiver's start-of-frame sync. It converts the receiver's level-style valid/err outputs into a proper buffered valid/ready byte stream. It also keeps frame and error statistics. It sits between the receiver and the downstream byte consumer.

---
 rtl/uart_rx_ctrl.sv | 168 ++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receiver sequencer: phase-locked 3-per-bit sample strobes, a FWFT byte buffer
// fed by the receiver's valid edges, and sticky frame/error statistics.
module uart_rx_ctrl #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned END_TIMEOUT  = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_enable,
    output logic        o_rxpulse,
    input  logic        i_rxsync,
    input  logic        i_rx_valid,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_err,
    output logic [7:0]  o_data,
    output logic        o_valid,
    input  logic        i_ready,
    output logic        o_busy,
    output logic        o_overrun,
    output logic        o_frame_err,
    input  logic        i_clr,
    output logic [15:0] o_frame_cnt,
    output logic [7:0]  o_err_cnt
);

    localparam int unsigned Q    = CLKS_PER_BIT / 4;
    localparam int unsigned PH_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned TM_W = $clog2(END_TIMEOUT + 1);
    localparam int unsigned AW   = $clog2(FIFO_DEPTH);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StActive  = 2'd1;
    localparam logic [1:0] StWaitEnd = 2'd2;

    localparam logic [PH_W-1:0] PhQ1   = PH_W'(Q);
    localparam logic [PH_W-1:0] PhQ2   = PH_W'(2 * Q);
    localparam logic [PH_W-1:0] PhQ3   = PH_W'(3 * Q);
    localparam logic [PH_W-1:0] PhLast = PH_W'(CLKS_PER_BIT - 1);
    localparam logic [TM_W-1:0] TmLast = TM_W'(END_TIMEOUT - 1);

    logic [1:0]      state_q, state_d;
    logic [PH_W-1:0] ph_q, ph_d;
    logic [4:0]      pc_q, pc_d;
    logic [TM_W-1:0] timer_q, timer_d;
    logic            valid_prev_q, err_prev_q;
    logic            valid_rise, err_rise, err_evt, pulse;

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW:0]     wr_ptr_q, rd_ptr_q;
    logic            empty, full, pop, push_ok, drop;

    logic [15:0]     frame_cnt_q;
    logic [7:0]      err_cnt_q;
    logic            overrun_q, frame_err_q;

    assign valid_rise = i_rx_valid & ~valid_prev_q;
    assign err_rise   = i_rx_err & ~err_prev_q;

    always_comb begin
        pulse = (state_q == StActive) && (ph_q == PhQ1 || ph_q == PhQ2 || ph_q == PhQ3);
    end

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        pc_d    = pc_q;
        timer_d = timer_q;
        err_evt = 1'b0;
        case (state_q)
            StIdle: begin
                if (i_rxsync && i_enable) begin
                    state_d = StActive;
                    ph_d    = '0;
                    pc_d    = '0;
                end
            end
            StActive: begin
                // A simultaneous valid edge outranks a start-bit rejection.
                if (err_rise && !valid_rise) begin
                    state_d = StIdle;
                    err_evt = 1'b1;
                end else if (pulse && pc_q == 5'd29) begin
                    state_d = StWaitEnd;
                    timer_d = '0;
                end else begin
                    ph_d = (ph_q == PhLast) ? '0 : ph_q + 1'b1;
                    if (pulse) pc_d = pc_q + 5'd1;
                end
            end
            StWaitEnd: begin
                if (valid_rise) begin
                    state_d = StIdle;
                end else if (err_rise || timer_q == TmLast) begin
                    state_d = StIdle;
                    err_evt = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= StIdle;
            ph_q         <= '0;
            pc_q         <= '0;
            timer_q      <= '0;
            valid_prev_q <= 1'b1;
            err_prev_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            ph_q         <= ph_d;
            pc_q         <= pc_d;
            timer_q      <= timer_d;
            valid_prev_q <= i_rx_valid;
            err_prev_q   <= i_rx_err;
        end
    end

    // A pop in the same cycle frees the slot a full buffer would otherwise refuse.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop     = ~empty & i_ready;
    assign push_ok = valid_rise & (~full | pop);
    assign drop    = valid_rise & full & ~pop;

    always_ff @(posedge i_clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= i_rx_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            if (i_clr) begin
                frame_cnt_q <= {15'd0, push_ok};
                err_cnt_q   <= {7'd0, err_evt};
                overrun_q   <= drop;
                frame_err_q <= err_evt;
            end else begin
                if (push_ok) frame_cnt_q <= frame_cnt_q + 16'd1;
                if (err_evt && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
                overrun_q   <= overrun_q | drop;
                frame_err_q <= frame_err_q | err_evt;
            end
        end
    end

    assign o_rxpulse   = pulse;
    assign o_busy      = (state_q != StIdle);
    assign o_valid     = ~empty;
    assign o_data      = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
    assign o_overrun   = overrun_q;
    assign o_frame_err = frame_err_q;
    assign o_frame_cnt = frame_cnt_q;
    assign o_err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: frame-timeline model checked every cycle, plus directed literal checks.
module tb_uart_rx_ctrl;

    localparam int C    = 16;
    localparam int Q    = C / 4;
    localparam int FD   = 4;
    localparam int ET   = 8;
    localparam int LAST = 9 * C + 3 * Q;  // age of the 30th pulse within a frame

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_enable = 1'b0;
    logic        i_rxsync = 1'b0;
    logic        i_rx_valid = 1'b1;
    logic [7:0]  i_rx_data = 8'h00;
    logic        i_rx_err = 1'b0;
    logic        i_ready = 1'b0;
    logic        i_clr = 1'b0;
    logic        o_rxpulse, o_valid, o_busy, o_overrun, o_frame_err;
    logic [7:0]  o_data, o_err_cnt;
    logic [15:0] o_frame_cnt;

    uart_rx_ctrl #(
        .CLKS_PER_BIT(C),
        .FIFO_DEPTH  (FD),
        .END_TIMEOUT (ET)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_enable   (i_enable),
        .o_rxpulse  (o_rxpulse),
        .i_rxsync   (i_rxsync),
        .i_rx_valid (i_rx_valid),
        .i_rx_data  (i_rx_data),
        .i_rx_err   (i_rx_err),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_busy     (o_busy),
        .o_overrun  (o_overrun),
        .o_frame_err(o_frame_err),
        .i_clr      (i_clr),
        .o_frame_cnt(o_frame_cnt),
        .o_err_cnt  (o_err_cnt)
    );

    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int pcount  = 0;
    int first_p = -1;
    int last_p  = -1;
    int cyc0    = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Model: a frame is an age counter from sync; outputs follow from the frame timeline.
    bit         m_ok = 0;
    bit         m_busy, m_vprev, m_eprev, m_ovr, m_ferr;
    int         m_age, m_frames, m_errs;
    logic [7:0] q[$];

    always @(negedge i_clk) begin
        bit vr, er, pop, acc, drp, err;
        int r;
        if (o_rxpulse === 1'b1) begin
            pcount++;
            if (first_p < 0) first_p = cyc;
            last_p = cyc;
        end
        if (m_ok) begin
            r = m_age % C;
            chk("rxpulse", 32'(o_rxpulse),
                32'(m_busy && m_age <= LAST && (r == Q || r == 2 * Q || r == 3 * Q)));
            chk("busy", 32'(o_busy), 32'(m_busy));
            chk("valid", 32'(o_valid), 32'(q.size() > 0));
            chk("data", 32'(o_data), (q.size() > 0) ? 32'(q[0]) : 32'd0);
            chk("overrun", 32'(o_overrun), 32'(m_ovr));
            chk("frame_err", 32'(o_frame_err), 32'(m_ferr));
            chk("frame_cnt", 32'(o_frame_cnt), 32'(m_frames));
            chk("err_cnt", 32'(o_err_cnt), 32'(m_errs));
        end
        if (i_rst) begin
            m_ok = 1; m_busy = 0; m_vprev = 1; m_eprev = 1; m_ovr = 0; m_ferr = 0;
            m_age = 0; m_frames = 0; m_errs = 0;
            q.delete();
        end else if (m_ok) begin
            vr = i_rx_valid && !m_vprev;
            er = i_rx_err && !m_eprev;
            m_vprev = i_rx_valid;
            m_eprev = i_rx_err;
            pop = (q.size() > 0) && i_ready;
            acc = vr && (q.size() < FD || pop);
            drp = vr && !acc;
            err = 0;
            if (!m_busy) begin
                if (i_rxsync && i_enable) begin m_busy = 1; m_age = 0; end
            end else if (m_age <= LAST) begin
                if (er && !vr) begin m_busy = 0; err = 1; end
                else m_age++;
            end else begin
                if (vr) m_busy = 0;
                else if (er || m_age == LAST + ET) begin m_busy = 0; err = 1; end
                else m_age++;
            end
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(i_rx_data);
            if (i_clr) begin
                m_frames = acc ? 1 : 0;
                m_errs   = err ? 1 : 0;
                m_ovr    = drp;
                m_ferr   = err;
            end else begin
                m_frames = (m_frames + (acc ? 1 : 0)) & 16'hFFFF;
                if (err && m_errs < 255) m_errs++;
                m_ovr  = m_ovr | drp;
                m_ferr = m_ferr | err;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        i_rx_valid = 1'b0;
        tick(1);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        tick(1);
    endtask

    task automatic start_frame();
        i_rxsync   = 1'b1;
        i_rx_valid = 1'b0;
        tick(1);
        i_rxsync   = 1'b0;
        cyc0       = cyc;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset while the receiver holds valid high: no push may follow.
        tick(3);
        i_rst = 1'b0;
        tick(4);
        chk("lit_reset_valid", 32'(o_valid), 32'd0);
        chk("lit_reset_busy", 32'(o_busy), 32'd0);
        chk("lit_reset_cnt", 32'(o_frame_cnt), 32'd0);

        // Full frame 0xA5.
        i_enable = 1'b1;
        pcount = 0; first_p = -1; last_p = -1;
        start_frame();
        tick(157);
        chk("lit_frame_waiting", 32'(o_busy), 32'd1);
        chk("lit_frame_novalid", 32'(o_valid), 32'd0);
        i_rx_data  = 8'hA5;
        i_rx_valid = 1'b1;
        tick(1);
        chk("lit_frame_pulses", 32'(pcount), 32'd30);
        chk("lit_first_pulse", 32'(first_p - cyc0), 32'd4);
        chk("lit_last_pulse", 32'(last_p - cyc0), 32'd156);
        chk("lit_frame_valid", 32'(o_valid), 32'd1);
        chk("lit_frame_data", 32'(o_data), 32'hA5);
        chk("lit_frame_cnt", 32'(o_frame_cnt), 32'd1);
        chk("lit_frame_idle", 32'(o_busy), 32'd0);
        i_ready = 1'b1;
        tick(1);
        i_ready = 1'b0;
        chk("lit_frame_popped", 32'(o_valid), 32'd0);

        // Start-bit rejection.
        start_frame();
        tick(5);
        i_rx_err = 1'b1;
        tick(1);
        chk("lit_glitch_busy", 32'(o_busy), 32'd0);
        chk("lit_glitch_pulse", 32'(o_rxpulse), 32'd0);
        chk("lit_glitch_errcnt", 32'(o_err_cnt), 32'd1);
        chk("lit_glitch_ferr", 32'(o_frame_err), 32'd1);
        i_rx_err = 1'b0;
        tick(1);

        // End timeout, then clear.
        start_frame();
        tick(157 + 7);
        chk("lit_timeout_pending", 32'(o_busy), 32'd1);
        tick(1);
        chk("lit_timeout_idle", 32'(o_busy), 32'd0);
        chk("lit_timeout_errcnt", 32'(o_err_cnt), 32'd2);
        i_clr = 1'b1;
        tick(1);
        i_clr = 1'b0;
        chk("lit_clr_errcnt", 32'(o_err_cnt), 32'd0);
        chk("lit_clr_framecnt", 32'(o_frame_cnt), 32'd0);
        chk("lit_clr_ferr", 32'(o_frame_err), 32'd0);

        // Overrun with consumer stalled.
        for (int i = 0; i < 5; i++) push_byte(8'hD0 + 8'(i));
        chk("lit_ovr_flag", 32'(o_overrun), 32'd1);
        chk("lit_ovr_cnt", 32'(o_frame_cnt), 32'd4);
        i_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("lit_ovr_drain", 32'(o_data), 32'(8'hD0 + 8'(i)));
            tick(1);
        end
        chk("lit_ovr_empty", 32'(o_valid), 32'd0);
        i_ready = 1'b0;

        // Full buffer with pop and push together.
        i_clr = 1'b1;
        tick(1);
        i_clr = 1'b0;
        for (int i = 0; i < 4; i++) push_byte(8'hE0 + 8'(i));
        i_rx_valid = 1'b0;
        tick(1);
        i_rx_data  = 8'hE4;
        i_rx_valid = 1'b1;
        i_ready    = 1'b1;
        tick(1);
        i_ready = 1'b0;
        chk("lit_pp_head", 32'(o_data), 32'hE1);
        chk("lit_pp_noovr", 32'(o_overrun), 32'd0);
        i_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            chk("lit_pp_drain", 32'(o_data), 32'(8'hE0 + 8'(i)));
            tick(1);
        end
        chk("lit_pp_empty", 32'(o_valid), 32'd0);
        i_ready = 1'b0;

        // Clear coinciding with a push.
        i_rx_valid = 1'b0;
        tick(1);
        i_rx_data  = 8'h3C;
        i_rx_valid = 1'b1;
        i_clr      = 1'b1;
        tick(1);
        i_clr = 1'b0;
        chk("lit_clr_push", 32'(o_frame_cnt), 32'd1);
        i_ready = 1'b1;
        tick(1);
        i_ready = 1'b0;

        // Sync ignored while disabled.
        i_enable = 1'b0;
        i_rxsync = 1'b1;
        tick(1);
        i_rxsync = 1'b0;
        chk("lit_disabled", 32'(o_busy), 32'd0);
        i_enable = 1'b1;

        // Error counter saturation.
        repeat (260) begin
            i_rxsync = 1'b1;
            tick(1);
            i_rxsync = 1'b0;
            i_rx_err = 1'b1;
            tick(1);
            i_rx_err = 1'b0;
            tick(1);
        end
        chk("lit_sat_errcnt", 32'(o_err_cnt), 32'd255);

        // Reset mid-frame with a byte buffered.
        push_byte(8'h77);
        start_frame();
        tick(61);
        chk("lit_midrst_busy", 32'(o_busy), 32'd1);
        i_rst      = 1'b1;
        i_rx_valid = 1'b1;
        tick(1);
        chk("lit_rst_pulse", 32'(o_rxpulse), 32'd0);
        chk("lit_rst_busy", 32'(o_busy), 32'd0);
        chk("lit_rst_fifo", 32'(o_valid), 32'd0);
        chk("lit_rst_errcnt", 32'(o_err_cnt), 32'd0);
        i_rst = 1'b0;
        pcount = 0;
        tick(4);
        chk("lit_postrst_valid", 32'(o_valid), 32'd0);
        chk("lit_postrst_cnt", 32'(o_frame_cnt), 32'd0);
        chk("lit_postrst_pulses", 32'(pcount), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
